ula_seq: RTL
============

# ula_seq

Sequencer that drives the 4-bit ULA (ALU) result-select datapath from the command side. It accepts one command at a time, `{op, a, b}`, over a valid/ready handshake and registers the operands and opcode onto the ULA inputs. It waits a fixed settle time, captures the selected ULA result and overflow, then returns them over a second valid/ready handshake. It sits between the control/switch-input logic and the combinational ULA.

## Interface

Parameters:
- `W`, default 4: operand/result width.
- `SETTLE`, default 1: cycles the ULA inputs are held before capture. Legal range 1..15.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 4: opcode.
  - 0 soma, 1 sub, 2 mult, 3 div, 4 igual, 5 maior, 6 menor, 7 dif.
  - 8 e, 9 n_e, 10 ou, 11 n_ou, 12 excl, 13 n_excl, 14 n_a, 15 n_b.
- `cmd_a` in W: operand A.
- `cmd_b` in W: operand B.
- `alu_op` out 4: registered opcode to the ULA select.
- `alu_a` out W: registered operand A to the ULA.
- `alu_b` out W: registered operand B to the ULA.
- `alu_out` in W: ULA selected result (combinational).
- `alu_ov` in 1: raw ULA overflow (OR of sum/mult overflow).
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out W: captured result.
- `res_op` out 4: opcode of the captured result.
- `res_ov` out 1: qualified overflow.
- `res_err` out 1: divide-by-zero flag.
- `busy` out 1: high whenever state is not IDLE.

## Operation

- FSM states: IDLE, WAIT, DONE. Settle counter `cnt` is 4 bits.
- **IDLE**
  - `cmd_ready = ~rst`.
  - On `cmd_valid & cmd_ready`:
    - load `alu_op/alu_a/alu_b` from `cmd_*`;
    - set `cnt = SETTLE-1`;
    - go to WAIT.
- **WAIT**
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`:
    - capture `res_data = alu_out` and `res_op = alu_op`;
    - capture `res_ov = alu_ov & (alu_op == 0 | alu_op == 2)`;
    - capture `res_err = 0`;
    - go to DONE.
- **DONE**
  - `res_valid = 1`; all `res_*` stay stable.
  - On `res_ready`: go to IDLE.
- Overflow is reported only for soma and mult. For every other opcode `res_ov = 0`, regardless of `alu_ov`.
- `alu_*` hold the last command after completion. They are never cleared except by reset.
- `cmd_valid` outside IDLE is ignored. It is not queued.
- Arithmetic is performed entirely by the ULA. The sequencer performs no width extension or truncation; `res_data` is `alu_out` bit-exact.

## Timing

- Reset (edge with `rst = 1`):
  - state goes to IDLE;
  - `cnt`, `alu_op`, `alu_a`, `alu_b`, `res_data`, `res_op`, `res_ov`, `res_err` all go to 0;
  - `res_valid = 0`, `busy = 0`.
  - `cmd_ready = 0` while `rst` is high, and 1 in the first cycle after.
- Reset in WAIT or DONE aborts the operation. No result is produced; a pending `res_valid` drops on the next cycle.
- Accept at edge T:
  - `alu_*` are valid from cycle T+1;
  - WAIT lasts `SETTLE` cycles;
  - `res_valid` rises in cycle T+SETTLE+1.
- `res_valid` and `res_ready` both high at edge R: IDLE from R+1. `cmd_ready` is high in cycle R+1.
- Maximum throughput: one command per `SETTLE+2` cycles.
- `res_ready` held low: DONE holds indefinitely with stable outputs and `cmd_ready = 0`.

## Configuration

- Macro: `ULA_SEQ_DIV0_EN`.
- Defined:
  - a command accepted with `cmd_op == 3` and `cmd_b == 0` skips WAIT;
  - the next state is DONE, with `res_data = 0`, `res_op = 3`, `res_ov = 0`, `res_err = 1`;
  - latency is accept → `res_valid` in 1 cycle;
  - `alu_*` are still loaded.
- Undefined:
  - `res_err` is a constant 0;
  - opcode 3 is sequenced like every other opcode, whatever `alu_out` returns.

## Test plan

- **Soma with overflow.** `SETTLE=1`, ULA model returns a sum mod 16. Command op=0, a=7, b=9 → `res_valid` 2 cycles after accept with `res_data=0`, `res_ov=1`, `res_err=0`, `res_op=0`.
- **Overflow masking.** op=1, a=3, b=5, model forces `alu_ov=1` → `res_ov=0` and `res_data = 4'hE`.
- **Divide by zero.** op=3, a=6, b=0.
  - With `ULA_SEQ_DIV0_EN`: `res_valid` 1 cycle after accept, `res_data=0`, `res_err=1`.
  - Without it: `res_valid` at `SETTLE+1` cycles, `res_err=0`.
- **Backpressure.** `res_ready` low for 5 cycles in DONE → `res_*` stable, `cmd_ready=0`. A `cmd_valid` pulse during that window produces no second result.
- **Reset mid-operation.** `SETTLE=8`, assert `rst` in the 3rd WAIT cycle → next cycle shows `busy=0`, `res_valid=0`, `alu_*=0`. After `rst` deasserts: `cmd_ready=1`, and a fresh command completes normally.
- **Back-to-back.** `SETTLE=2`, `cmd_valid` and `res_ready` tied high, 4 commands → accepts spaced exactly 4 cycles apart; results in order with the correct `res_op`.

Source files
------------

// File: rtl/ula_seq.sv
// Command sequencer for the 4-bit ULA: registers {op,a,b}, settles, captures.
// Optional macro ULA_SEQ_DIV0_EN short-circuits divide-by-zero to an error.
module ula_seq #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ov,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [3:0]   res_op,
  output logic         res_ov,
  output logic         res_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     alu_op_q, alu_op_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic [3:0]     res_op_q, res_op_d;
  logic           res_ov_q, res_ov_d;
  logic           res_valid_q, res_valid_d;
  logic           busy_q, busy_d;
`ifdef ULA_SEQ_DIV0_EN
  logic           res_err_q, res_err_d;
`endif
  logic           accept;
  logic           ov_op;

  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  // Only soma and mult have a meaningful overflow.
  assign ov_op     = (alu_op_q == 4'd0) | (alu_op_q == 4'd2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    res_ov_d   = res_ov_q;
`ifdef ULA_SEQ_DIV0_EN
    res_err_d  = res_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          alu_op_d = cmd_op;
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          cnt_d    = CNT_INIT;
          state_d  = WAIT;
`ifdef ULA_SEQ_DIV0_EN
          if (cmd_op == 4'd3 && cmd_b == '0) begin
            res_data_d = '0;
            res_op_d   = 4'd3;
            res_ov_d   = 1'b0;
            res_err_d  = 1'b1;
            state_d    = DONE;
          end
`endif
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_data_d = alu_out;
          res_op_d   = alu_op_q;
          res_ov_d   = alu_ov & ov_op;
`ifdef ULA_SEQ_DIV0_EN
          res_err_d  = 1'b0;
`endif
          state_d    = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_ov_q    <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ULA_SEQ_DIV0_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_ov_q    <= res_ov_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
`ifdef ULA_SEQ_DIV0_EN
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_ov    = res_ov_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
`ifdef ULA_SEQ_DIV0_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule
